// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a word-wide memory.
// Sub-word stores are done as read-modify-write.
module load_store_unit #(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [31:0] old_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic [29:0] req_widx;
    logic        req_oor;
    logic        req_fault;
    logic        accept;
    logic [31:0] merge_word;
    logic [31:0] load_val;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign req_widx = req_addr[31:2];
    assign req_oor  = (req_widx >> MEM_ADDR_WIDTH) != '0;

    assign req_fault = (req_size == 2'b11)
                     | ((req_size == 2'b01) & req_addr[0])
                     | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                     | req_oor;

    assign accept = req_valid & req_ready;

    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;

    // Replace the addressed lanes of the captured word with store data.
    always_comb begin
        merge_word = old_q;
        unique case (1'b1)
            size_q == 2'b10: merge_word = wdata_q;
            size_q == 2'b01: begin
                if (addr_q[1])
                    merge_word[31:16] = wdata_q[15:0];
                else
                    merge_word[15:0] = wdata_q[15:0];
            end
            default: merge_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        endcase
    end

    // Pick the load lane from the memory word and extend it.
    always_comb begin
        ld_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        unique case (size_q)
            2'b00:   load_val = {{24{~uns_q & ld_b[7]}}, ld_b};
            2'b01:   load_val = {{16{~uns_q & ld_h[15]}}, ld_h};
            default: load_val = mem_rdata;
        endcase
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_fault)
                        state_d = RESP;
                    else if (req_we && req_size == 2'b10)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                mem_addr = {2'b00, addr_q[31:2]};
                state_d  = we_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_rw    = 1'b1;
                mem_addr  = {2'b00, addr_q[31:2]};
                mem_wdata = merge_word;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus request latch and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
            old_q   <= 32'd0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
                rdata_q <= 32'd0;
                fault_q <= req_fault;
            end
            if (state_q == READ) begin
                old_q <= mem_rdata;
                if (!we_q)
                    rdata_q <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a word-array
// reference model of the byte-addressed memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    int          wcnt = 0;
    logic [31:0] last_w = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_ADDR_WIDTH(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_fault  (resp_fault),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rw      (mem_rw),
        .mem_rdata   (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:0]];

    // Attached memory: write on edge, count write pulses.
    always @(posedge clk) begin
        if (mem_rw) begin
            mem[mem_addr[9:0]] <= mem_wdata;
            wcnt   <= wcnt + 1;
            last_w <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: fault rule and load/store results from plain arithmetic.
    function automatic logic ref_fault(input logic [1:0] sz,
                                       input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        if ((a / 4) >= 1024) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] wd, input int stall,
                          output logic [31:0] rd, output int lat);
        logic        e_flt;
        logic [31:0] e_rd, word, v, mask, e_word;
        int          e_lat, e_pulses, sh, w0, idx;
        e_flt = ref_fault(sz, a);
        idx   = int'(a / 4) % 1024;
        word  = ref_mem[idx];
        sh    = int'(a % 4) * 8;
        mask  = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        e_rd  = 32'd0;
        e_word = word;
        e_pulses = 0;
        if (e_flt) begin
            e_lat = 1;
        end else if (!we) begin
            e_lat = 2;
            v = (word >> sh) & mask;
            if (!uns && sz == 2'd0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
            if (!uns && sz == 2'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
            e_rd = v;
        end else begin
            e_lat = (sz == 2'd2) ? 2 : 3;
            e_pulses = 1;
            e_word = (word & ~(mask << sh)) | ((wd & mask) << sh);
            ref_mem[idx] = e_word;
        end
        w0 = wcnt;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, e_lat);
        check("resp_valid", {31'd0, resp_valid}, 32'd1);
        rd = resp_rdata;
        check("resp_rdata", resp_rdata, e_rd);
        check("resp_fault", {31'd0, resp_fault}, {31'd0, e_flt});
        for (int i = 0; i < stall; i++) begin
            check("stall_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
            check("stall_valid", {31'd0, resp_valid}, 32'd1);
            check("stall_rdata", resp_rdata, e_rd);
            check("stall_fault", {31'd0, resp_fault}, {31'd0, e_flt});
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_drop", {31'd0, resp_valid}, 32'd0);
        check("ready_back", {31'd0, req_ready}, 32'd1);
        check("pulses", wcnt - w0, e_pulses);
        if (e_pulses != 0)
            check("mem_word", mem[idx], e_word);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, v, a;
        logic [1:0]  sz;
        int          lat, w0;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[1] = 32'h80FF_1234;
        ref_mem[1] = 32'h80FF_1234;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        check("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        do_req(1'b0, 2'd0, 1'b0, 32'h5, 32'd0, 0, rd, lat);
        check("lb_0x5", rd, 32'h0000_0012);
        check("lb_0x5_lat", lat, 32'd2);
        do_req(1'b0, 2'd1, 1'b0, 32'h6, 32'd0, 0, rd, lat);
        check("lh_0x6", rd, 32'hFFFF_80FF);

        do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h1122_3344, 0, rd, lat);
        w0 = wcnt;
        do_req(1'b1, 2'd0, 1'b0, 32'h6, 32'h0000_00AB, 0, rd, lat);
        check("sb_wdata", last_w, 32'h11AB_3344);
        check("sb_pulses", wcnt - w0, 32'd1);
        check("sb_lat", lat, 32'd3);

        w0 = wcnt;
        do_req(1'b0, 2'd2, 1'b0, 32'h2, 32'd0, 0, rd, lat);
        check("mis_lat", lat, 32'd1);
        check("mis_fault", {31'd0, resp_fault}, 32'd1);
        do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'd0, 0, rd, lat);
        check("ill_fault", {31'd0, resp_fault}, 32'd1);
        do_req(1'b1, 2'd2, 1'b0, 32'h1000, 32'h1234_5678, 0, rd, lat);
        check("oor_fault", {31'd0, resp_fault}, 32'd1);
        check("fault_nowrite", wcnt - w0, 32'd0);

        do_req(1'b0, 2'd1, 1'b1, 32'h4, 32'd0, 5, rd, lat);
        check("stall_lhu", rd, 32'h0000_3344);

        w0 = wcnt;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h9; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_in_read", mem_addr, 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("abort_rdata", resp_rdata, 32'd0);
        check("abort_fault", {31'd0, resp_fault}, 32'd0);
        check("abort_mem_rw", {31'd0, mem_rw}, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_mem_wdata", mem_wdata, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_nowrite", wcnt - w0, 32'd0);
        check("abort_mem", mem[2], ref_mem[2]);

        do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF, 0, rd, lat);
        do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'd0, 0, rd, lat);
        check("sw_lw", rd, 32'hDEAD_BEEF);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 9) == 0)
                a = $urandom | 32'h0000_1000;
            else
                a = $urandom_range(0, 4095);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   a, $urandom, $urandom_range(0, 2), rd, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
